// File: rtl/sram_req_ctrl.sv
// ============================================================================
// Module  : sram_req_ctrl
// Brief   : Arbitrates write/read requests onto a two-bank SRAM port, buffers
//           read responses in a 3-entry FIFO, and runs a bulk-clear sequencer.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module sram_req_ctrl #(
  parameter int DW = 8,
  parameter int AW = 11
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wr_valid,
  output logic            wr_ready,
  input  logic [AW-1:0]   wr_addr,
  input  logic            wr_bank,
  input  logic [DW-1:0]   wr_data,
  input  logic            rd_valid,
  output logic            rd_ready,
  input  logic [AW-1:0]   rd_addr,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [2*DW-1:0] rsp_data,
  input  logic            clr_start,
  input  logic [DW-1:0]   clr_value,
  output logic            clr_busy,
  output logic            sram_cen,
  output logic            sram_wen,
  output logic            sram_sel,
  output logic [AW-1:0]   sram_addr,
  output logic [DW-1:0]   sram_din,
  input  logic [2*DW-1:0] sram_dout
);

  typedef enum logic [1:0] {IDLE = 2'd0, CLR_LO = 2'd1, CLR_HI = 2'd2} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]   clrv_q, clrv_d;
  logic            cen_q, cen_d, wen_q, wen_d, sel_q, sel_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   din_q, din_d;
  logic            p1_q, p2_q;   // read issued one / two edges ago
  logic            rr_q;         // 0: write wins next contention
  logic            en_q;         // readies held low until first edge after reset
  logic [2*DW-1:0] mem_q [3];
  logic [1:0]      rptr_q, wptr_q, fcnt_q;

  logic       pop, busy, rd_elig, wr_elig, contend, grant_w, grant_r;
  logic [2:0] occ;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  assign busy      = (state_q != IDLE);
  assign rsp_valid = (fcnt_q != 2'd0);
  assign rsp_data  = mem_q[rptr_q];
  assign pop       = rsp_valid && rsp_ready;
  // Occupancy counts reads still in the SRAM pipeline so a new read always has a slot.
  assign occ       = {1'b0, fcnt_q} - {2'b00, pop} + {2'b00, p1_q} + {2'b00, p2_q};
  assign wr_elig   = en_q && !busy;
  assign rd_elig   = en_q && !busy && (occ < 3'd3);
  assign contend   = wr_valid && wr_elig && rd_valid && rd_elig;
  assign grant_w   = wr_valid && wr_elig && !(contend && rr_q);
  assign grant_r   = rd_valid && rd_elig && !(contend && !rr_q);
  assign wr_ready  = wr_elig && !grant_r;
  assign rd_ready  = rd_elig && !grant_w;
  assign clr_busy  = busy;

  assign sram_cen  = cen_q;
  assign sram_wen  = wen_q;
  assign sram_sel  = sel_q;
  assign sram_addr = addr_q;
  assign sram_din  = din_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clrv_d  = clrv_q;
    cen_d   = 1'b1;
    wen_d   = 1'b1;
    sel_d   = sel_q;
    addr_d  = addr_q;
    din_d   = din_q;
    if (grant_w) begin
      cen_d  = 1'b0;
      wen_d  = 1'b0;
      sel_d  = wr_bank;
      addr_d = wr_addr;
      din_d  = wr_data;
    end else if (grant_r) begin
      cen_d  = 1'b0;
      addr_d = rd_addr;
    end
    case (state_q)
      IDLE: begin
        if (clr_start && en_q) begin
          state_d = CLR_LO;
          clrv_d  = clr_value;
          cnt_d   = '0;
        end
      end
      CLR_LO, CLR_HI: begin
        // Hold off until reads already issued have been captured.
        if (!p1_q && !p2_q) begin
          cen_d  = 1'b0;
          wen_d  = 1'b0;
          sel_d  = (state_q == CLR_HI);
          addr_d = cnt_q;
          din_d  = clrv_q;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == {AW{1'b1}}) state_d = (state_q == CLR_LO) ? CLR_HI : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      clrv_q  <= '0;
      cen_q   <= 1'b1;
      wen_q   <= 1'b1;
      sel_q   <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
      p1_q    <= 1'b0;
      p2_q    <= 1'b0;
      rr_q    <= 1'b0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      clrv_q  <= clrv_d;
      cen_q   <= cen_d;
      wen_q   <= wen_d;
      sel_q   <= sel_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      p1_q    <= grant_r;
      p2_q    <= p1_q;
      en_q    <= 1'b1;
      if (contend) rr_q <= grant_w;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) mem_q[i] <= '0;
      rptr_q <= '0;
      wptr_q <= '0;
      fcnt_q <= '0;
    end else begin
      if (p2_q) begin
        mem_q[wptr_q] <= sram_dout;
        wptr_q        <= ptr_inc(wptr_q);
      end
      if (pop) rptr_q <= ptr_inc(rptr_q);
      fcnt_q <= fcnt_q + {1'b0, p2_q} - {1'b0, pop};
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sram_req_ctrl.sv
// ============================================================================
// Module  : tb_sram_req_ctrl
// Brief   : Directed bench for sram_req_ctrl with a two-bank SRAM model.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_sram_req_ctrl;
  localparam int DW = 8;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_valid, wr_ready, wr_bank, rd_valid, rd_ready;
  logic [AW-1:0] wr_addr, rd_addr, sram_addr;
  logic [DW-1:0] wr_data, clr_value, sram_din;
  logic          rsp_valid, rsp_ready, clr_start, clr_busy;
  logic [15:0]   rsp_data, sram_dout;
  logic          sram_cen, sram_wen, sram_sel;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;

  logic [7:0] lo_mem [16];
  logic [7:0] hi_mem [16];

  sram_req_ctrl #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
    .wr_bank(wr_bank), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .clr_start(clr_start), .clr_value(clr_value), .clr_busy(clr_busy),
    .sram_cen(sram_cen), .sram_wen(sram_wen), .sram_sel(sram_sel),
    .sram_addr(sram_addr), .sram_din(sram_din), .sram_dout(sram_dout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous SRAM: read data appears after the edge following the issue edge.
  always @(posedge clk) begin
    if (!sram_cen) begin
      if (!sram_wen) begin
        if (sram_sel) hi_mem[sram_addr] <= sram_din;
        else          lo_mem[sram_addr] <= sram_din;
      end else begin
        sram_dout <= {hi_mem[sram_addr], lo_mem[sram_addr]};
      end
    end
  end

  typedef struct {
    logic [3:0]  addr;
    logic [7:0]  lo;
    logic [7:0]  hi;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs [4];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_write(input logic b, input logic [3:0] a, input logic [7:0] d);
    bit ok = 0;
    wr_valid = 1'b1; wr_bank = b; wr_addr = a; wr_data = d;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clk);
      if (wr_ready) ok = 1;
      @(posedge clk); #1;
    end
    wr_valid = 1'b0;
    if (!ok) check("wr_timeout", 0, 1);
  endtask

  task automatic do_read(input logic [3:0] a, output int hs);
    bit ok = 0;
    hs = -1;
    rd_valid = 1'b1; rd_addr = a;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clk);
      if (rd_ready) ok = 1;
      @(posedge clk); #1;
      if (ok) hs = cyc;
    end
    rd_valid = 1'b0;
    if (!ok) check("rd_timeout", 0, 1);
  endtask

  task automatic wait_rsp(input logic [15:0] exp, input string nm, output int vc);
    bit got = 0;
    vc = -1;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      if (rsp_valid) begin
        got = 1;
        vc = cyc;
        check(nm, rsp_data, exp);
      end
      @(posedge clk); #1;
    end
    if (!got) check("rsp_timeout", 0, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs, vc, k, r, nrsp, busy_n, widx, bad, rc, wc;
    logic [3:0]  bp_addr [5];
    logic [15:0] bp_exp  [5];
    string       gseq, gexp;

    vecs[0] = '{4'd5,  8'hA5, 8'h3C, 16'h3CA5};
    vecs[1] = '{4'd0,  8'h00, 8'hFF, 16'hFF00};
    vecs[2] = '{4'd15, 8'hFF, 8'h01, 16'h01FF};
    vecs[3] = '{4'd3,  8'h5A, 8'hC3, 16'hC35A};
    bp_addr = '{4'd5, 4'd0, 4'd15, 4'd3, 4'd5};
    bp_exp  = '{16'h3CA5, 16'hFF00, 16'h01FF, 16'hC35A, 16'h3CA5};

    for (int i = 0; i < 16; i++) begin lo_mem[i] = '0; hi_mem[i] = '0; end
    sram_dout = '0;
    rst_n = 1'b0; wr_valid = 0; wr_bank = 0; wr_addr = '0; wr_data = '0;
    rd_valid = 0; rd_addr = '0; rsp_ready = 1'b1; clr_start = 0; clr_value = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ctl", {sram_cen, sram_wen, sram_sel, rsp_valid, clr_busy, wr_ready, rd_ready}, 7'b1100000);
    check("rst_addr_din", {sram_addr, sram_din}, 12'h000);
    check("rst_rsp_data", rsp_data, 16'h0000);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Write both banks, read back, check data and two-edge latency.
    for (int i = 0; i < 4; i++) begin
      do_write(1'b0, vecs[i].addr, vecs[i].lo);
      do_write(1'b1, vecs[i].addr, vecs[i].hi);
      do_read(vecs[i].addr, hs);
      wait_rsp(vecs[i].exp, "tbl_data", vc);
      check("tbl_latency", vc - hs, 2);
    end

    // Contention: both valid for four cycles.
    wr_valid = 1; wr_bank = 1; wr_addr = 4'd9; wr_data = 8'h9C;
    rd_valid = 1; rd_addr = 4'd5;
    gseq = ""; gexp = "WRWR"; nrsp = 0;
    for (int i = 0; i < 16 && nrsp < 2; i++) begin
      @(negedge clk);
      if (i < 4) gseq = {gseq, wr_ready ? "W" : (rd_ready ? "R" : "-")};
      if (rsp_valid) begin
        check("cont_data", rsp_data, 16'h3CA5);
        nrsp++;
      end
      @(posedge clk); #1;
      if (i == 3) begin wr_valid = 0; rd_valid = 0; end
    end
    wr_valid = 0; rd_valid = 0;
    for (int i = 0; i < 4; i++) check("cont_grant", gseq.getc(i), gexp.getc(i));
    check("cont_nrsp", nrsp, 2);

    // Back-pressure: five reads with responses stalled.
    rsp_ready = 0; k = 0; rd_valid = 1; rd_addr = bp_addr[0];
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rd_valid && rd_ready) k++;
      @(posedge clk); #1;
      rd_valid = (k < 5);
      rd_addr  = bp_addr[(k < 5) ? k : 4];
    end
    check("bp_accepts", k, 3);
    @(negedge clk);
    check("bp_rd_ready_low", rd_ready, 0);
    check("bp_rsp_stable", {rsp_valid, rsp_data}, {1'b1, bp_exp[0]});
    @(posedge clk); #1;
    rsp_ready = 1; r = 0;
    for (int i = 0; i < 40 && r < 5; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        check("bp_order", rsp_data, bp_exp[r]);
        r++;
      end
      if (rd_valid && rd_ready) k++;
      @(posedge clk); #1;
      rd_valid = (k < 5);
      rd_addr  = bp_addr[(k < 5) ? k : 4];
    end
    rd_valid = 0;
    check("bp_nrsp", r, 5);
    check("bp_nacc", k, 5);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("bp_no_extra", rsp_valid, 0);
    @(posedge clk); #1;

    // Clear with 0x77: 32 busy cycles, low bank then high bank.
    clr_value = 8'h77; clr_start = 1;
    @(posedge clk); #1;
    clr_start = 0;
    busy_n = 0; widx = 0; bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (clr_busy) busy_n++;
      if (!sram_cen && !sram_wen) begin
        if (sram_sel !== (widx >= 16) || sram_addr !== 4'(widx % 16)) bad++;
        widx++;
      end
      if (!clr_busy) break;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    check("clr_busy_cycles", busy_n, 32);
    check("clr_writes", widx, 32);
    check("clr_seq_errors", bad, 0);
    do_read(4'd7, hs);
    wait_rsp(16'h7777, "clr_rd7", vc);
    do_read(4'd0, hs);
    wait_rsp(16'h7777, "clr_rd0", vc);

    // Clear requested one cycle after a read handshake.
    do_write(1'b0, 4'd2, 8'h12);
    do_write(1'b1, 4'd2, 8'h34);
    rd_valid = 1; rd_addr = 4'd2;
    @(negedge clk);
    check("r38_hs", rd_ready, 1);
    @(posedge clk); #1;
    rd_valid = 0; hs = cyc;
    clr_value = 8'h99; clr_start = 1;
    @(posedge clk); #1;
    clr_start = 0; rc = -1; wc = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (rsp_valid && rc < 0) begin
        rc = cyc;
        check("r38_data", rsp_data, 16'h3412);
      end
      if (!sram_cen && !sram_wen && wc < 0) wc = cyc;
      if (!clr_busy) break;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    check("r38_rsp_latency", rc - hs, 2);
    check("r38_clr_after_capture", (wc > rc) ? 1 : 0, 1);

    // Reset in the middle of a clear.
    clr_value = 8'h55; clr_start = 1;
    @(posedge clk); #1;
    clr_start = 0;
    repeat (10) @(posedge clk);
    #1 rst_n = 0;
    #1;
    check("rmid_ctl", {sram_cen, sram_wen, sram_sel, rsp_valid, clr_busy, wr_ready, rd_ready}, 7'b1100000);
    check("rmid_addr_din", {sram_addr, sram_din}, 12'h000);
    check("rmid_rsp_data", rsp_data, 16'h0000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk); #1;
    wr_valid = 1; wr_bank = 0; wr_addr = 4'd1; wr_data = 8'hEE;
    @(negedge clk);
    check("rmid_wr_ready", {clr_busy, wr_ready}, 2'b01);
    @(posedge clk); #1;
    wr_valid = 0;
    do_read(4'd1, hs);
    wait_rsp(16'h99EE, "rmid_rdback", vc);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
